cv32e41s_obi_data_responder: RTL and testbench



---
 rtl/cv32e41s_pkg.sv | 37 +++
 rtl/cv32e41s_tcm_lfsr.sv | 29 ++
 rtl/cv32e41s_obi_data_responder.sv | 148 ++++++++++++++
 tb/tb_cv32e41s_obi_data_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e41s_pkg.sv
// Purpose : shared types and constants for the OBI data-side TCM responder.
// Latency : n/a (types, constants and a pure LFSR step function only).
// Backpressure : n/a.
package cv32e41s_pkg;

  // OBI data request carried alongside req/gnt.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  memtype;
    logic [2:0]  prot;
    logic        dbg;
  } obi_data_req_t;

  // OBI data response carried alongside rvalid.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        exokay;
  } obi_data_resp_t;

  typedef enum logic [0:0] {
    TCM_IDLE,
    TCM_WAIT
  } tcm_resp_state_e;

  localparam logic [15:0] TCM_LFSR_SEED  = 16'hACE1;
  localparam int          TCM_WAIT_CNT_W = 4;

  // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] tcm_lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/cv32e41s_tcm_lfsr.sv
// Purpose : free-standing 16-bit Fibonacci LFSR used to randomise TCM grant stalls.
// Latency : state advances on the clock edge after en_i is sampled high.
// Backpressure : none; en_i simply gates the step.
// Ports: clk/rst_n (async active-low, reloads seed), en_i (advance), lfsr_o (current state).
module cv32e41s_tcm_lfsr
  import cv32e41s_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = en_i ? tcm_lfsr_next(lfsr_q) : lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= TCM_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/cv32e41s_obi_data_responder.sv
// Purpose : OBI data-side subordinate; performs granted transfers on a single-port SRAM.
// Latency : gnt_o WAIT_STATES (+0..3 random with CV32E41S_TCM_RANDOM_STALL_EN) cycles after req_i;
//           rvalid_o exactly 1 cycle after the handshake.
// Backpressure : req/gnt on the request side only; responses cannot be stalled (no rready).
// Ports: req_i/gnt_o/trans_i request channel, rvalid_o/resp_o response channel,
//        mem_* single-port synchronous SRAM (read data one cycle after enable).
// Optional: define CV32E41S_TCM_RANDOM_STALL_EN to add LFSR-driven extra grant stalls.
module cv32e41s_obi_data_responder
  import cv32e41s_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE      = 32'h0001_0000,
  parameter int          MEM_ADDR_WIDTH = 14,
  parameter int          WAIT_STATES    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  obi_data_req_t             trans_i,
  output logic                      rvalid_o,
  output obi_data_resp_t            resp_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [3:0]                mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [31:0]               mem_rdata_i
);

  // Random stalls can push the total wait up to 15+3, so the counter needs one more bit.
`ifdef CV32E41S_TCM_RANDOM_STALL_EN
  localparam int CNT_W = TCM_WAIT_CNT_W + 1;
`else
  localparam int CNT_W = TCM_WAIT_CNT_W;
`endif

  tcm_resp_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wait_total;
  logic [1:0]       extra_stall;
  logic             handshake;
  logic             in_range;
  logic [31:0]      addr_off;
  logic [32:0]      addr_w, lo_w, hi_w;
  logic             rvalid_q, err_q, rd_q;
  logic             unused_sigs;

  assign handshake = req_i && gnt_o;

`ifdef CV32E41S_TCM_RANDOM_STALL_EN
  logic [15:0] lfsr;

  cv32e41s_tcm_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (handshake),
    .lfsr_o (lfsr)
  );

  // The LFSR only moves on handshakes, so the extra count is stable while a request waits.
  assign extra_stall = lfsr[1:0];
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr[15:2];
`else
  assign extra_stall = 2'b00;
`endif

  assign wait_total = CNT_W'(WAIT_STATES) + CNT_W'(extra_stall);

  // Grant FSM: a zero total wait grants in the request cycle, otherwise the counter
  // is loaded with total-1 so the grant lands exactly 'total' cycles after req_i rose.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_o   = 1'b0;
    case (state_q)
      TCM_IDLE: begin
        if (req_i) begin
          if (wait_total == '0) begin
            gnt_o = 1'b1;
          end else begin
            cnt_d   = wait_total - CNT_W'(1);
            state_d = TCM_WAIT;
          end
        end
      end
      TCM_WAIT: begin
        if (cnt_q == '0) begin
          gnt_o   = req_i;
          state_d = TCM_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = TCM_IDLE;
    endcase
  end

  // 33-bit window compare so a window ending at 32'hFFFF_FFFF does not wrap.
  assign addr_w   = {1'b0, trans_i.addr[31:2], 2'b00};
  assign lo_w     = {1'b0, ADDR_BASE};
  assign hi_w     = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE} - 33'd1;
  assign in_range = (addr_w >= lo_w) && (addr_w <= hi_w);
  assign addr_off = trans_i.addr - ADDR_BASE;

  assign mem_req_o   = handshake && in_range;
  assign mem_we_o    = trans_i.we;
  assign mem_be_o    = trans_i.be;
  assign mem_wdata_o = trans_i.wdata;
  assign mem_addr_o  = addr_off[MEM_ADDR_WIDTH+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TCM_IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= handshake;
      err_q    <= handshake && !in_range;
      rd_q     <= handshake && in_range && !trans_i.we;
    end
  end

  // err_q/rd_q are only set alongside rvalid_q, so an idle response is all zero.
  always_comb begin
    resp_o        = '0;
    resp_o.rdata  = rd_q ? mem_rdata_i : 32'h0;
    resp_o.err    = err_q;
    resp_o.exokay = 1'b0;
  end
  assign rvalid_o = rvalid_q;

  // memtype/prot/dbg do not affect a plain non-bufferable TCM.
  assign unused_sigs = ^{trans_i.memtype, trans_i.prot, trans_i.dbg,
                         addr_off[1:0], addr_off[31:MEM_ADDR_WIDTH+2]};

`ifndef SYNTHESIS
  // Initiator must hold the request and its payload until granted.
  a_req_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (req_i && !gnt_o) |=> (req_i && $stable(trans_i)));
`endif

endmodule

// File: tb/tb_cv32e41s_obi_data_responder.sv
`timescale 1ns/1ps
module tb_cv32e41s_obi_data_responder;
  import cv32e41s_pkg::*;

`ifdef CV32E41S_TCM_RANDOM_STALL_EN
  localparam int STALL_MAX = 3;
`else
  localparam int STALL_MAX = 0;
`endif

  logic           clk;
  logic           rst_n;
  logic           req       [3];
  obi_data_req_t  trans;
  logic           gnt       [3];
  logic           rvalid    [3];
  obi_data_resp_t resp      [3];
  logic           mem_req   [3];
  logic           mem_we    [3];
  logic [3:0]     mem_be    [3];
  logic [13:0]    mem_addr  [3];
  logic [31:0]    mem_wdata [3];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: base 0, no waits. Instance 1: base 0, 3 waits. Instance 2: base FFFF_0000.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] sram [16384];
    logic [31:0] rd_q;

    cv32e41s_obi_data_responder #(
      .ADDR_BASE      (g == 2 ? 32'hFFFF_0000 : 32'h0000_0000),
      .ADDR_SIZE      (32'h0001_0000),
      .MEM_ADDR_WIDTH (14),
      .WAIT_STATES    (g == 1 ? 3 : 0)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req[g]),
      .gnt_o       (gnt[g]),
      .trans_i     (trans),
      .rvalid_o    (rvalid[g]),
      .resp_o      (resp[g]),
      .mem_req_o   (mem_req[g]),
      .mem_we_o    (mem_we[g]),
      .mem_be_o    (mem_be[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_rdata_i (rd_q)
    );

    always @(posedge clk) begin
      if (mem_req[g]) begin
        if (mem_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[g][b]) sram[mem_addr[g]][8*b +: 8] = mem_wdata[g][8*b +: 8];
        end else begin
          rd_q <= (sram[mem_addr[g]] === 32'hx) ? 32'h0 : sram[mem_addr[g]];
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] base_of(input int k);
    return (k == 2) ? 32'hFFFF_0000 : 32'h0000_0000;
  endfunction

  function automatic int ws_of(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  function automatic bit ref_in(input int k, input logic [31:0] a);
    longint aa, b;
    aa = longint'({a[31:2], 2'b00});
    b  = longint'(base_of(k));
    return (aa >= b) && (aa < b + 64'h1_0000);
  endfunction

  function automatic int ref_key(input int k, input logic [31:0] a);
    logic [31:0] off;
    off = a - base_of(k);
    return k * 16384 + int'(off[15:2]);
  endfunction

  // Applies one transfer to the model and returns the read data it must produce.
  function automatic logic [31:0] ref_access(input int k, input logic [31:0] a, input logic we,
                                             input logic [3:0] be, input logic [31:0] wd);
    int key;
    logic [31:0] old, nw;
    if (!ref_in(k, a)) return 32'h0;
    key = ref_key(k, a);
    old = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    if (!we) return old;
    nw = old;
    for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wd[8*b +: 8];
    ref_mem[key] = nw;
    return 32'h0;
  endfunction

  task automatic set_trans(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
    trans         = '0;
    trans.addr    = a;
    trans.we      = we;
    trans.be      = be;
    trans.wdata   = wd;
    trans.memtype = 2'($urandom);
    trans.prot    = 3'($urandom);
    trans.dbg     = 1'($urandom);
  endtask

  // Single non-pipelined transfer; reports grant delay, grant-cycle SRAM signals,
  // whether mem_req/rvalid fired early, and the response one cycle after the grant.
  task automatic xfer(input int k, input logic [31:0] a, input logic we, input logic [3:0] be,
                      input logic [31:0] wd, output int dly, output logic g_mreq,
                      output logic [13:0] g_maddr, output logic early, output logic rv,
                      output obi_data_resp_t r);
    dly   = 0;
    early = 1'b0;
    @(posedge clk); #1;
    set_trans(a, we, be, wd);
    req[k] = 1'b1;
    @(negedge clk);
    while (!gnt[k] && dly < 40) begin
      if (mem_req[k] || rvalid[k]) early = 1'b1;
      @(negedge clk);
      dly++;
    end
    g_mreq  = mem_req[k];
    g_maddr = mem_addr[k];
    if (gnt[k]) void'(ref_access(k, a, we, be, wd));
    @(posedge clk); #1;
    req[k] = 1'b0;
    @(negedge clk);
    rv = rvalid[k];
    r  = resp[k];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (rvalid[k] !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid[%0d]: got %b want 0", k, rvalid[k]); end
      n_checks++; if (resp[k] !== '0) begin n_errors++; $display("FAIL reset_resp[%0d]: got %h want 0", k, resp[k]); end
      n_checks++; if (gnt[k] !== 1'b0) begin n_errors++; $display("FAIL reset_gnt[%0d]: got %b want 0", k, gnt[k]); end
      n_checks++; if (mem_req[k] !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req[%0d]: got %b want 0", k, mem_req[k]); end
    end
  endtask

  task automatic test_basic;
    int dly; logic mr, early, rv; logic [13:0] ma; obi_data_resp_t r;
    xfer(0, 32'h0000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, dly, mr, ma, early, rv, r);
    n_checks++; if (dly < 0 || dly > STALL_MAX) begin n_errors++; $display("FAIL basic_wr_delay: got %0d want 0..%0d", dly, STALL_MAX); end
    n_checks++; if (mr !== 1'b1 || ma !== 14'd4) begin n_errors++; $display("FAIL basic_wr_mem: got req=%b addr=%h want req=1 addr=004", mr, ma); end
    n_checks++; if (rv !== 1'b1 || r !== {32'h0, 1'b0, 1'b0}) begin n_errors++; $display("FAIL basic_wr_resp: got rv=%b resp=%h want rv=1 resp=0", rv, r); end
    xfer(0, 32'h0000_0010, 1'b0, 4'hF, 32'h0, dly, mr, ma, early, rv, r);
    n_checks++; if (dly < 0 || dly > STALL_MAX) begin n_errors++; $display("FAIL basic_rd_delay: got %0d want 0..%0d", dly, STALL_MAX); end
    n_checks++; if (rv !== 1'b1 || r !== {32'hDEAD_BEEF, 1'b0, 1'b0}) begin n_errors++; $display("FAIL basic_rd_resp: got rv=%b resp=%h want DEADBEEF err=0", rv, r); end
    // Low address bits are ignored.
    xfer(0, 32'h0000_0013, 1'b0, 4'hF, 32'h0, dly, mr, ma, early, rv, r);
    n_checks++; if (r !== {32'hDEAD_BEEF, 1'b0, 1'b0}) begin n_errors++; $display("FAIL basic_rd_unaligned: got %h want DEADBEEF err=0", r); end
  endtask

  task automatic test_back_to_back;
    int dly; logic mr, early, rv; logic [13:0] ma; obi_data_resp_t r;
    xfer(0, 32'h0000_0020, 1'b1, 4'hF, 32'hFFFF_FFFF, dly, mr, ma, early, rv, r);
`ifndef CV32E41S_TCM_RANDOM_STALL_EN
    @(posedge clk); #1;
    set_trans(32'h0000_0020, 1'b1, 4'b0011, 32'h1234_5678);
    req[0] = 1'b1;
    @(negedge clk);
    n_checks++; if (gnt[0] !== 1'b1) begin n_errors++; $display("FAIL b2b_gnt_wr: got %b want 1", gnt[0]); end
    void'(ref_access(0, 32'h0000_0020, 1'b1, 4'b0011, 32'h1234_5678));
    @(posedge clk); #1;
    set_trans(32'h0000_0020, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    n_checks++; if (gnt[0] !== 1'b1) begin n_errors++; $display("FAIL b2b_gnt_rd: got %b want 1", gnt[0]); end
    n_checks++; if (rvalid[0] !== 1'b1 || resp[0] !== '0) begin n_errors++; $display("FAIL b2b_wr_resp: got rv=%b resp=%h want rv=1 resp=0", rvalid[0], resp[0]); end
    void'(ref_access(0, 32'h0000_0020, 1'b0, 4'hF, 32'h0));
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (rvalid[0] !== 1'b1 || resp[0] !== {32'hFFFF_5678, 1'b0, 1'b0}) begin n_errors++; $display("FAIL b2b_rd_resp: got rv=%b resp=%h want FFFF5678", rvalid[0], resp[0]); end
    @(negedge clk);
    n_checks++; if (rvalid[0] !== 1'b0) begin n_errors++; $display("FAIL b2b_idle: got rvalid=%b want 0", rvalid[0]); end
`else
    xfer(0, 32'h0000_0020, 1'b1, 4'b0011, 32'h1234_5678, dly, mr, ma, early, rv, r);
    xfer(0, 32'h0000_0020, 1'b0, 4'hF, 32'h0, dly, mr, ma, early, rv, r);
    n_checks++; if (r !== {32'hFFFF_5678, 1'b0, 1'b0}) begin n_errors++; $display("FAIL b2b_rd_resp: got %h want FFFF5678", r); end
`endif
  endtask

  task automatic test_wait_states;
    int dly; logic mr, early, rv; logic [13:0] ma; obi_data_resp_t r;
    xfer(1, 32'h0000_0040, 1'b1, 4'hF, 32'hAA55_00FF, dly, mr, ma, early, rv, r);
    n_checks++; if (dly < 3 || dly > 3 + STALL_MAX) begin n_errors++; $display("FAIL ws_wr_delay: got %0d want 3..%0d", dly, 3 + STALL_MAX); end
    xfer(1, 32'h0000_0040, 1'b0, 4'hF, 32'h0, dly, mr, ma, early, rv, r);
    n_checks++; if (dly < 3 || dly > 3 + STALL_MAX) begin n_errors++; $display("FAIL ws_rd_delay: got %0d want 3..%0d", dly, 3 + STALL_MAX); end
    n_checks++; if (early !== 1'b0) begin n_errors++; $display("FAIL ws_early: got mem_req/rvalid before grant=%b want 0", early); end
    n_checks++; if (mr !== 1'b1 || ma !== 14'h010) begin n_errors++; $display("FAIL ws_mem: got req=%b addr=%h want req=1 addr=010", mr, ma); end
    n_checks++; if (rv !== 1'b1 || r !== {32'hAA55_00FF, 1'b0, 1'b0}) begin n_errors++; $display("FAIL ws_rd_resp: got rv=%b resp=%h want AA5500FF", rv, r); end
  endtask

  task automatic test_decode;
    int dly; logic mr, early, rv; logic [13:0] ma; obi_data_resp_t r;
    xfer(0, 32'h0000_FFFC, 1'b1, 4'hF, 32'h0BAD_F00D, dly, mr, ma, early, rv, r);
    n_checks++; if (mr !== 1'b1 || ma !== 14'h3FFF) begin n_errors++; $display("FAIL dec_top_mem: got req=%b addr=%h want req=1 addr=3FFF", mr, ma); end
    xfer(0, 32'h0000_FFFC, 1'b0, 4'hF, 32'h0, dly, mr, ma, early, rv, r);
    n_checks++; if (r !== {32'h0BAD_F00D, 1'b0, 1'b0}) begin n_errors++; $display("FAIL dec_top_rd: got %h want 0BADF00D err=0", r); end
    xfer(0, 32'h0001_0000, 1'b0, 4'hF, 32'h0, dly, mr, ma, early, rv, r);
    n_checks++; if (mr !== 1'b0 || early !== 1'b0) begin n_errors++; $display("FAIL dec_oor_memreq: got %b want 0", mr); end
    n_checks++; if (rv !== 1'b1 || r !== {32'h0, 1'b1, 1'b0}) begin n_errors++; $display("FAIL dec_oor_resp: got rv=%b resp=%h want rdata=0 err=1", rv, r); end
    xfer(0, 32'h0001_0000, 1'b1, 4'hF, 32'h5555_5555, dly, mr, ma, early, rv, r);
    n_checks++; if (mr !== 1'b0 || r !== {32'h0, 1'b1, 1'b0}) begin n_errors++; $display("FAIL dec_oor_wr: got req=%b resp=%h want req=0 err=1", mr, r); end
    xfer(2, 32'hFFFF_FFFC, 1'b1, 4'hF, 32'hCAFE_0001, dly, mr, ma, early, rv, r);
    n_checks++; if (mr !== 1'b1 || ma !== 14'h3FFF) begin n_errors++; $display("FAIL dec_hi_mem: got req=%b addr=%h want req=1 addr=3FFF", mr, ma); end
    xfer(2, 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, dly, mr, ma, early, rv, r);
    n_checks++; if (r !== {32'hCAFE_0001, 1'b0, 1'b0}) begin n_errors++; $display("FAIL dec_hi_rd: got %h want CAFE0001 err=0", r); end
    xfer(2, 32'h0000_0000, 1'b0, 4'hF, 32'h0, dly, mr, ma, early, rv, r);
    n_checks++; if (mr !== 1'b0 || r !== {32'h0, 1'b1, 1'b0}) begin n_errors++; $display("FAIL dec_hi_wrap: got req=%b resp=%h want req=0 err=1", mr, r); end
    xfer(2, 32'hFFFE_FFFC, 1'b0, 4'hF, 32'h0, dly, mr, ma, early, rv, r);
    n_checks++; if (mr !== 1'b0 || r !== {32'h0, 1'b1, 1'b0}) begin n_errors++; $display("FAIL dec_hi_below: got req=%b resp=%h want req=0 err=1", mr, r); end
  endtask

  task automatic test_reset_mid;
    int dly; logic mr, early, rv; logic [13:0] ma; obi_data_resp_t r;
    int w = 0;
    @(posedge clk); #1;
    set_trans(32'h0000_0010, 1'b0, 4'hF, 32'h0);
    req[0] = 1'b1;
    @(negedge clk);
    while (!gnt[0] && w < 40) begin @(negedge clk); w++; end
    n_checks++; if (gnt[0] !== 1'b1) begin n_errors++; $display("FAIL rstmid_gnt: got %b want 1", gnt[0]); end
    @(posedge clk); #1;
    req[0] = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    n_checks++; if (rvalid[0] !== 1'b0 || resp[0] !== '0) begin n_errors++; $display("FAIL rstmid_during: got rv=%b resp=%h want 0", rvalid[0], resp[0]); end
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (rvalid[0] !== 1'b0 || resp[0] !== '0) begin n_errors++; $display("FAIL rstmid_after: got rv=%b resp=%h want 0", rvalid[0], resp[0]); end
    xfer(0, 32'h0000_0010, 1'b0, 4'hF, 32'h0, dly, mr, ma, early, rv, r);
    n_checks++; if (rv !== 1'b1 || r !== {32'hDEAD_BEEF, 1'b0, 1'b0}) begin n_errors++; $display("FAIL rstmid_read: got rv=%b resp=%h want DEADBEEF", rv, r); end
  endtask

  // Streaming random traffic with back-to-back requests, checked against the model.
  task automatic test_random(input int k, input int n);
    obi_data_resp_t expq[$];
    obi_data_resp_t e;
    logic [31:0] a;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    int issued = 0, cyc = 0, start = 0, guard = 0, r;
    bit active = 0;
    int lo = ws_of(k);
    @(posedge clk); #1;
    while ((issued < n || expq.size() != 0) && guard < 20000) begin
      if (!active) req[k] = 1'b0;
      if (!active && issued < n && ($urandom_range(0, 3) != 0)) begin
        r = $urandom_range(0, 9);
        if (r == 0)      a = base_of(k) + 32'h0001_0000 + ($urandom & 32'h00FF_FFFF);
        else if (r == 1) a = base_of(k) + 32'h0000_FFC0 + $urandom_range(0, 63);
        else             a = base_of(k) + $urandom_range(0, 255);
        we = 1'($urandom);
        be = 4'($urandom);
        wd = $urandom;
        set_trans(a, we, be, wd);
        req[k] = 1'b1;
        active = 1;
        start  = cyc;
      end
      @(negedge clk);
      n_checks++;
      if (rvalid[k] !== (expq.size() == 1)) begin
        n_errors++; $display("FAIL rnd%0d_rvalid: got %b want %b (xfer %0d)", k, rvalid[k], expq.size() == 1, issued);
      end
      if (rvalid[k] === 1'b1 && expq.size() != 0) begin
        e = expq.pop_front();
        n_checks++; if (resp[k] !== e) begin n_errors++; $display("FAIL rnd%0d_resp: got %h want %h", k, resp[k], e); end
      end else if (expq.size() != 0) begin
        void'(expq.pop_front());
      end
      if (active && gnt[k] === 1'b1) begin
        n_checks++;
        if (cyc - start < lo || cyc - start > lo + STALL_MAX) begin
          n_errors++; $display("FAIL rnd%0d_delay: got %0d want %0d..%0d", k, cyc - start, lo, lo + STALL_MAX);
        end
        n_checks++;
        if (mem_req[k] !== ref_in(k, a)) begin
          n_errors++; $display("FAIL rnd%0d_mem_req: got %b want %b addr=%h", k, mem_req[k], ref_in(k, a), a);
        end
        e.rdata  = ref_access(k, a, we, be, wd);
        e.err    = !ref_in(k, a);
        e.exokay = 1'b0;
        expq.push_back(e);
        issued++;
        active = 0;
      end else if (active) begin
        n_checks++; if (mem_req[k] !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_early_mem_req: got %b want 0", k, mem_req[k]); end
        if (cyc - start > 40) begin
          n_errors++; $display("FAIL rnd%0d_timeout: no grant after %0d cycles want <=%0d", k, cyc - start, lo + STALL_MAX);
          break;
        end
      end
      @(posedge clk); #1;
      cyc++;
      guard++;
    end
    req[k] = 1'b0;
    n_checks++; if (issued != n) begin n_errors++; $display("FAIL rnd%0d_count: got %0d want %0d", k, issued, n); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    trans = '0;
    #3 rst_n = 1'b0;
    test_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_basic();
    test_back_to_back();
    test_wait_states();
    test_decode();
    test_reset_mid();
    test_random(0, 1000);
    test_random(1, 200);
    test_random(2, 200);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
